// File: rtl/psum_accumulator.sv
// psum_accumulator
//   Accumulates D-lane signed partial sums from the PE mesh over a group of
//   transfers (firstPass .. lastPass), saturating each lane to W bits, then
//   presents the group result on a valid/ready output port.
//
//   Optional feature: define PSUM_ACCUMULATOR_RELU_EN to clamp each lane of
//   the published result at zero (ReLU). The accumulator and satFlag are not
//   affected by this option.
module psum_accumulator #(
  parameter int depth = 2,
  parameter int D     = (1 << depth),
  parameter int W     = 16
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [W*D-1:0] psumIn,
  input  logic           psumValid,
  output logic           psumReady,
  input  logic           firstPass,
  input  logic           lastPass,
  output logic [W*D-1:0] outData,
  output logic           outValid,
  input  logic           outReady,
  output logic           satFlag,
  output logic [7:0]     passCount
);

  typedef enum logic [1:0] {IDLE, ACC, DRAIN} state_t;

  localparam logic [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

  state_t               state_q;
  logic [D-1:0][W-1:0]  acc_q, acc_d;
  logic [D-1:0][W-1:0]  out_data_q, out_data_d;
  logic [D-1:0][W-1:0]  lane_w;
  logic [D-1:0][W:0]    sum_w;
  logic [D-1:0]         lane_sat_w;
  logic                 grp_sat_q, grp_sat_d;
  logic                 sat_flag_q;
  logic                 out_valid_q;
  logic [7:0]           pass_count_q, pass_count_d;
  logic                 xfer_w;
  logic                 load_w;

  // Lane i of psumIn occupies bits [W*(i+1)-1 -: W], which is exactly the
  // packing of a [D-1:0][W-1:0] packed array.
  assign lane_w    = psumIn;

  // Ready comes from state only, so the input side never waits on outReady.
  assign psumReady = (state_q != DRAIN);
  assign xfer_w    = psumValid && psumReady;

  // A transfer in IDLE always opens a fresh group, whatever firstPass says.
  assign load_w    = firstPass || (state_q == IDLE);

  // Next accumulator value, group saturation and pass count for a transfer.
  always_comb begin
    // NOTE: every variable gets a default before any branch; otherwise a
    // path that skips an assignment would infer a latch.
    acc_d        = acc_q;
    grp_sat_d    = grp_sat_q;
    pass_count_d = pass_count_q;
    sum_w        = '0;
    lane_sat_w   = '0;
    for (int i = 0; i < D; i++) begin
      // One extra bit holds the exact sum; the top two bits disagree only
      // when the W-bit result would have wrapped.
      sum_w[i] = {acc_q[i][W-1], acc_q[i]} + {lane_w[i][W-1], lane_w[i]};
      if (sum_w[i][W] != sum_w[i][W-1]) begin
        lane_sat_w[i] = 1'b1;
      end
    end
    if (xfer_w) begin
      if (load_w) begin
        acc_d        = lane_w;
        grp_sat_d    = 1'b0;
        pass_count_d = 8'd1;
      end else begin
        for (int i = 0; i < D; i++) begin
          if (lane_sat_w[i]) begin
            acc_d[i] = sum_w[i][W] ? MIN_V : MAX_V;
          end else begin
            acc_d[i] = sum_w[i][W-1:0];
          end
        end
        grp_sat_d    = grp_sat_q | (|lane_sat_w);
        pass_count_d = (pass_count_q == 8'hFF) ? 8'hFF : pass_count_q + 8'd1;
      end
    end
  end

  // Result lanes as they will be published from the post-update accumulator.
  always_comb begin
    out_data_d = acc_d;
`ifdef PSUM_ACCUMULATOR_RELU_EN
    for (int i = 0; i < D; i++) begin
      if (acc_d[i][W-1]) begin
        out_data_d[i] = '0;
      end
    end
`endif
  end

  // Control FSM with registered datapath and outputs; reset wins over all.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (RST) begin
      state_q      <= IDLE;
      // NOTE: the accumulator lanes are plain flops, not a RAM, so they are
      // reset along with the rest of the state.
      acc_q        <= '0;
      grp_sat_q    <= 1'b0;
      pass_count_q <= 8'd0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      sat_flag_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ACC: begin
          if (xfer_w) begin
            acc_q        <= acc_d;
            grp_sat_q    <= grp_sat_d;
            pass_count_q <= pass_count_d;
            if (lastPass) begin
              out_data_q  <= out_data_d;
              sat_flag_q  <= grp_sat_d;
              out_valid_q <= 1'b1;
              state_q     <= DRAIN;
            end else begin
              state_q <= ACC;
            end
          end
        end
        DRAIN: begin
          if (out_valid_q && outReady) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign outData   = out_data_q;
  assign outValid  = out_valid_q;
  assign satFlag   = sat_flag_q;
  assign passCount = pass_count_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator
//   Self-checking bench for psum_accumulator (D=4, W=16). A behavioural model
//   keeps integer lane sums per group and predicts each published result.
module tb_psum_accumulator;

  localparam int DEPTH = 2;
  localparam int D     = 1 << DEPTH;
  localparam int W     = 16;
  localparam int MAXV  = (1 << (W-1)) - 1;
  localparam int MINV  = -(1 << (W-1));

  logic           CLK = 1'b0;
  logic           RST;
  logic [W*D-1:0] psumIn;
  logic           psumValid;
  logic           psumReady;
  logic           firstPass;
  logic           lastPass;
  logic [W*D-1:0] outData;
  logic           outValid;
  logic           outReady;
  logic           satFlag;
  logic [7:0]     passCount;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int             m_acc [D];
  bit             m_active;
  bit             m_sat;
  int             m_cnt;
  logic [W*D-1:0] m_out;
  bit             m_out_sat;

  psum_accumulator #(.depth(DEPTH), .D(D), .W(W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .psumIn    (psumIn),
    .psumValid (psumValid),
    .psumReady (psumReady),
    .firstPass (firstPass),
    .lastPass  (lastPass),
    .outData   (outData),
    .outValid  (outValid),
    .outReady  (outReady),
    .satFlag   (satFlag),
    .passCount (passCount)
  );

  always #5 CLK = ~CLK;

  function automatic int clamp(input int v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  function automatic logic [W*D-1:0] lanes4(input int a, input int b, input int c, input int d);
    logic [W*D-1:0] r;
    r[0*W +: W] = a[W-1:0];
    r[1*W +: W] = b[W-1:0];
    r[2*W +: W] = c[W-1:0];
    r[3*W +: W] = d[W-1:0];
    return r;
  endfunction

  function automatic logic [W*D-1:0] model_result();
    logic [W*D-1:0] r;
    int v;
    for (int i = 0; i < D; i++) begin
      v = m_acc[i];
`ifdef PSUM_ACCUMULATOR_RELU_EN
      if (v < 0) v = 0;
`endif
      r[i*W +: W] = v[W-1:0];
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) m_acc[i] = 0;
    m_active  = 0;
    m_sat     = 0;
    m_cnt     = 0;
    m_out     = '0;
    m_out_sat = 0;
  endtask

  task automatic model_xfer(input logic [W*D-1:0] v, input bit f, input bit l);
    int lane, s;
    if (!m_active || f) begin
      for (int i = 0; i < D; i++) m_acc[i] = int'($signed(v[i*W +: W]));
      m_sat = 0;
      m_cnt = 1;
    end else begin
      for (int i = 0; i < D; i++) begin
        lane = int'($signed(v[i*W +: W]));
        s = m_acc[i] + lane;
        if (clamp(s) != s) m_sat = 1;
        m_acc[i] = clamp(s);
      end
      m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
    end
    if (l) begin
      m_active  = 0;
      m_out     = model_result();
      m_out_sat = m_sat;
    end else begin
      m_active = 1;
    end
  endtask

  // One transfer, presented on a falling edge and accepted on the next rise.
  task automatic send(input logic [W*D-1:0] v, input bit f, input bit l);
    @(negedge CLK);
    psumIn    = v;
    firstPass = f;
    lastPass  = l;
    psumValid = 1'b1;
    checks++;
    if (psumReady !== 1'b1) begin
      errors++;
      $display("FAIL send_ready got=%b exp=1", psumReady);
    end
    @(posedge CLK);
    #1;
    psumValid = 1'b0;
    firstPass = 1'b0;
    lastPass  = 1'b0;
    model_xfer(v, f, l);
  endtask

  // Check the pending result, stall the consumer, then complete the handshake.
  task automatic drain(input string tag, input int stall);
    logic [W*D-1:0] held;
    @(negedge CLK);
    checks++;
    if (outValid !== 1'b1) begin
      errors++; $display("FAIL %s out_valid got=%b exp=1", tag, outValid);
    end
    checks++;
    if (outData !== m_out) begin
      errors++; $display("FAIL %s out_data got=%h exp=%h", tag, outData, m_out);
    end
    checks++;
    if (satFlag !== m_out_sat) begin
      errors++; $display("FAIL %s sat_flag got=%b exp=%b", tag, satFlag, m_out_sat);
    end
    checks++;
    if (passCount !== 8'(m_cnt)) begin
      errors++; $display("FAIL %s pass_count got=%0d exp=%0d", tag, passCount, m_cnt);
    end
    held = outData;
    for (int k = 0; k < stall; k++) begin
      // Traffic offered while draining must be ignored.
      psumIn    = {$urandom, $urandom};
      firstPass = 1'($urandom_range(0, 1));
      lastPass  = 1'($urandom_range(0, 1));
      psumValid = 1'b1;
      @(negedge CLK);
      checks++;
      if (psumReady !== 1'b0 || outValid !== 1'b1 || outData !== held) begin
        errors++;
        $display("FAIL %s stall ready=%b valid=%b data=%h exp ready=0 valid=1 data=%h",
                 tag, psumReady, outValid, outData, held);
      end
    end
    psumValid = 1'b0;
    firstPass = 1'b0;
    lastPass  = 1'b0;
    outReady  = 1'b1;
    @(posedge CLK);
    #1;
    outReady = 1'b0;
    @(negedge CLK);
    checks++;
    if (outValid !== 1'b0 || psumReady !== 1'b1) begin
      errors++;
      $display("FAIL %s after_hs valid=%b ready=%b exp valid=0 ready=1", tag, outValid, psumReady);
    end
    checks++;
    if (outData !== m_out || satFlag !== m_out_sat) begin
      errors++;
      $display("FAIL %s hold data=%h sat=%b exp data=%h sat=%b", tag, outData, satFlag, m_out, m_out_sat);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (outValid !== 1'b0 || outData !== '0 || satFlag !== 1'b0 ||
        passCount !== 8'd0 || psumReady !== 1'b1) begin
      errors++;
      $display("FAIL %s valid=%b data=%h sat=%b cnt=%0d ready=%b exp 0/0/0/0/1",
               tag, outValid, outData, satFlag, passCount, psumReady);
    end
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    model_reset();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    model_reset();
    @(negedge CLK);
    check_reset_outputs("reset");
  endtask

  task automatic test_basic();
    logic [W*D-1:0] v = lanes4(100, 100, 100, 100);
    send(v, 1, 0);
    send(v, 0, 0);
    checks++;
    if (outValid !== 1'b0 || passCount !== 8'd2) begin
      errors++; $display("FAIL basic_mid valid=%b cnt=%0d exp valid=0 cnt=2", outValid, passCount);
    end
    send(v, 0, 1);
    checks++;
    if (m_out !== lanes4(300, 300, 300, 300)) begin
      errors++; $display("FAIL basic_model got=%h exp=%h", m_out, lanes4(300, 300, 300, 300));
    end
    drain("basic", 0);
  endtask

  task automatic test_saturation();
    send(lanes4('h7000, 1, -3, 0), 1, 0);
    send(lanes4('h2000, 2, -4, 0), 0, 1);
    drain("sat_pos", 1);
    send(lanes4(MINV + 10, 0, 0, 0), 1, 0);
    send(lanes4(-20, 0, 0, 0), 0, 1);
    drain("sat_neg", 0);
    send(lanes4(10, 20, 30, 40), 1, 0);
    send(lanes4(1, 2, 3, 4), 0, 1);
    drain("sat_clear", 0);
  endtask

  task automatic test_single_pass();
    send(lanes4(5, -5, 0, 1), 1, 1);
    drain("single", 0);
  endtask

  task automatic test_back_pressure();
    send(lanes4(7, -8, 9, -10), 1, 0);
    send(lanes4(1, 1, 1, 1), 0, 1);
    drain("backpressure", 10);
    send(lanes4(3, 3, 3, 3), 0, 1);
    drain("after_bp", 0);
  endtask

  task automatic test_reset_mid();
    send(lanes4(11, 22, 33, 44), 1, 0);
    send(lanes4(11, 22, 33, 44), 0, 0);
    pulse_reset();
    check_reset_outputs("reset_acc");
    send(lanes4(1, 2, 3, 4), 0, 0);
    send(lanes4(1, 2, 3, 4), 0, 1);
    drain("post_reset", 0);
    send(lanes4(9, 9, 9, 9), 1, 1);
    pulse_reset();
    check_reset_outputs("reset_drain");
  endtask

  task automatic test_first_mid();
    send(lanes4(100, 100, 100, 100), 1, 0);
    send(lanes4(50, 50, 50, 50), 0, 0);
    send(lanes4(7, 7, 7, 7), 1, 0);
    send(lanes4(3, 3, 3, 3), 0, 1);
    drain("first_mid", 0);
  endtask

  task automatic test_pass_count_sat();
    for (int k = 0; k < 260; k++) send('0, k == 0, k == 259);
    drain("count_sat", 0);
  endtask

  task automatic test_random();
    int n;
    logic [W*D-1:0] v;
    for (int g = 0; g < 30; g++) begin
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) begin
        if (g % 2 == 0) begin
          for (int i = 0; i < D; i++) v[i*W +: W] = W'($urandom_range(0, 2000) - 1000);
        end else begin
          v = {$urandom, $urandom};
        end
        send(v, (k == 0) ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0),
             k == n - 1);
      end
      drain("random", $urandom_range(0, 3));
    end
  endtask

  initial begin
    RST       = 1'b1;
    psumIn    = '0;
    psumValid = 1'b0;
    firstPass = 1'b0;
    lastPass  = 1'b0;
    outReady  = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_saturation();
    test_single_pass();
    test_back_pressure();
    test_reset_mid();
    test_first_mid();
    test_pass_count_sat();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/psum_accumulator.md
PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

Interface
REQ-001 The block SHALL have parameter depth, default 2, meaning log2 of the PE mesh dimension.
REQ-002 The block SHALL have parameter D, default (1<<depth), meaning the number of mesh rows, which is also the number of lanes.
REQ-003 The block SHALL have parameter W, default 16, meaning the signed partial-sum width per lane.
REQ-004 CLK  input  1  meaning the single clock; all logic is rising-edge.
REQ-005 RST  input  1  meaning synchronous, active-high reset.
REQ-006 psumIn  input  W*D  meaning the mesh partialSumOut vector; lane i is bits [W*(i+1)-1 -: W].
REQ-007 psumValid  input  1  meaning psumIn is valid this cycle.
REQ-008 psumReady  output  1  meaning the block can accept psumIn this cycle.
REQ-009 firstPass  input  1  meaning the transfer starts a new accumulation group.
REQ-010 lastPass  input  1  meaning the transfer closes the current accumulation group.
REQ-011 outData  output  W*D  meaning the accumulated result vector, with the same lane packing as psumIn.
REQ-012 outValid  output  1  meaning outData holds a completed result.
REQ-013 outReady  input  1  meaning the consumer accepts outData.
REQ-014 satFlag  output  1  meaning at least one lane saturated in the group now on outData.
REQ-015 passCount  output  8  meaning the number of transfers in the current group; it saturates at 255.

Function
REQ-016 A transfer SHALL occur on any cycle where psumValid=1 and psumReady=1; no other input cycle changes state.
REQ-017 The FSM SHALL have exactly three states, IDLE, ACC and DRAIN, with the following transitions:
- IDLE to ACC on a transfer without lastPass.
- IDLE or ACC to DRAIN on a transfer with lastPass.
- DRAIN to IDLE on outValid and outReady both high.
REQ-018 psumReady SHALL be 1 in IDLE and ACC and 0 in DRAIN, so no transfer is accepted in the cycle DRAIN exits.
REQ-019 A transfer with firstPass=1 SHALL load every lane: acc[i] <= lane i, passCount <= 1, and the group saturation bit cleared.
REQ-020 A transfer made in IDLE SHALL be treated as firstPass=1 regardless of the firstPass input.
REQ-021 A transfer in ACC with firstPass=0 SHALL do the following:
- Set acc[i] <= sat(acc[i] + lane i), where the sum is computed W+1 bits wide and clamped to [-2^(W-1), 2^(W-1)-1].
- Increment passCount.
- Set the group saturation bit if any lane clamps.
REQ-022 A transfer in ACC with firstPass=1 SHALL discard the prior group and load as in REQ-019.
REQ-023 A transfer with firstPass=1 and lastPass=1 SHALL form a single-pass group: load, then enter DRAIN.
REQ-024 On a lastPass transfer, the following SHALL be registered from the post-update accumulator value:
- outData.
- satFlag.
- outValid=1, asserted on the next cycle (latency 1 cycle).
REQ-025 In DRAIN, outData, satFlag and outValid SHALL stay stable until the outValid and outReady handshake completes.
REQ-026 After the handshake, outValid SHALL be 0 on the next cycle, and outData and satFlag SHALL hold their last values.
REQ-027 The input handshake SHALL NOT combinationally depend on outReady.

Reset
REQ-028 While RST=1 at a clock edge, the following SHALL be set:
- State to IDLE.
- acc to 0.
- outData to 0.
- outValid to 0.
- satFlag to 0.
- passCount to 0.
- psumReady to 1 from the next cycle.
REQ-029 RST asserted during ACC or DRAIN SHALL drop the partial group or pending result with no output handshake.
REQ-030 RST SHALL take priority over a simultaneous transfer or output handshake.

Configuration
REQ-031 When macro PSUM_ACCUMULATOR_RELU_EN is defined, each lane loaded into outData SHALL be max(value, 0); acc and satFlag are unaffected.
REQ-032 When PSUM_ACCUMULATOR_RELU_EN is undefined, outData SHALL carry the signed accumulator value unmodified.

Verification
REQ-033 The bench SHALL cover these directed scenarios (D=4, W=16):
- Scenario A: three transfers with all lanes=100 (first, -, last) -> outValid one cycle after the third transfer, every lane=300, passCount=3, satFlag=0.
- Scenario B: lane0=0x7000 then lane0=0x2000 (last) -> lane0=0x7FFF, satFlag=1; a following group with no overflow -> satFlag=0.
- Scenario C: single transfer with firstPass=lastPass=1, lanes {5,-5,0,1} -> outData lanes equal {5,-5,0,1}, or {5,0,0,1} when PSUM_ACCUMULATOR_RELU_EN is defined.
- Scenario D: outReady=0 for 10 cycles while in DRAIN -> outData stable, psumReady=0, psumValid ignored; outReady=1 -> IDLE and psumReady=1 on the next cycle.
- Scenario E: RST pulsed after two ACC transfers -> all outputs return to reset values; a new group sums only post-reset data.
- Scenario F: firstPass asserted mid-group in ACC -> the earlier partial sum is discarded and the result equals the new group only.
